imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot-time controller that fills the byte-addressed, big-endian instruction memory from a byte stream. It then releases the processor core. It sits between an external byte source (UART/debug bridge) and the instruction memory's write port. It sequences load, checksum verification and core release, and holds the core in reset until a verified image is resident.

## Interface
- `ADDR_W`, default 7: instruction-memory byte-address width; capacity is 2^ADDR_W bytes.
- `LEN_W`, default 6: width of the word-count input.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE, RUN, ERROR.
- `load_len`  in  LEN_W  number of 32-bit instruction words to load; sampled with `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory byte write strobe.
- `mem_addr`  out  ADDR_W  byte address of the write.
- `mem_wdata`  out  8  byte to write.
- `cpu_run`  out  1  high = core released; low = core held in reset.
- `busy`  out  1  high in LOAD or CHECK.
- `err`  out  1  high in ERROR.

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERROR.
- Stream format: `load_len`×4 image bytes, then 1 checksum byte equal to the XOR of all image bytes.
- Byte order: first byte goes to address 0. The byte at address a is bits [31:24] of the word at a. Word n occupies addresses 4n..4n+3, MSB first.
- IDLE: `start` with 1 ≤ `load_len` ≤ 2^ADDR_W/4 → LOAD. On entry, address counter = 0, checksum = 0, and target = `load_len`×4−1 (computed at ADDR_W+1 bits, no truncation). `start` with `load_len` = 0 or too large → ERROR.
- LOAD: `byte_ready` = 1. A handshake occurs when `byte_valid` and `byte_ready` are both high. On each handshake:
  - write the byte at the address counter;
  - XOR the byte into the checksum;
  - increment the counter.
  - The handshake at counter = target → CHECK.
- CHECK: `byte_ready` = 1. One handshake compares `byte_data` with the checksum: equal → RUN, else → ERROR. No memory write occurs.
- RUN: `cpu_run` = 1. `start` with a valid length → LOAD, dropping `cpu_run`; an invalid length → ERROR.
- ERROR: `err` = 1, `cpu_run` = 0. `start` re-evaluates exactly as in IDLE.
- `start` is ignored in LOAD and CHECK.
- Memory contents written before an error or reset are not cleared.

## Timing
- Reset: state = IDLE and all outputs 0: `byte_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_run`, `busy`, `err`. The counter and checksum are also cleared.
- `byte_ready`, `busy`, `err`, `cpu_run` decode the current state only (Moore). None of them depends combinationally on `byte_valid` or `start`.
- `mem_we`, `mem_addr`, `mem_wdata` are registered. A handshake in cycle t produces `mem_we` = 1 with that address and byte in cycle t+1. `mem_we` lasts exactly 1 cycle per byte.
- Back-to-back handshakes give one write per cycle. Gaps in `byte_valid` stall the counter with no writes.
- `start` in IDLE/RUN/ERROR at cycle t → new state visible at t+1. `cpu_run` falls at t+1.
- Checksum handshake at t → `cpu_run` or `err` rises at t+1.
- Minimum load: 4×`load_len`+1 handshake cycles after entering LOAD.
- Asynchronous reset mid-load aborts immediately: `cpu_run` stays 0 and `byte_ready` drops without waiting for a clock edge.
- The address counter never wraps: the length check guarantees the last byte lands at or below 2^ADDR_W−1.

## Structure
- Shared package `imem_pkg`: the state enum (IDLE/LOAD/CHECK/RUN/ERROR), `ADDR_W` default, and the derived `IMEM_BYTES` = 2^ADDR_W and `IMEM_MAX_WORDS` = IMEM_BYTES/4. The instruction memory and core reuse these constants.
- One natural sub-module: `xor_checksum`, an 8-bit accumulator with clear and enable strobes. Everything else (FSM, counter, write register) stays in the top.

## Test plan
- Reset, `start` with `load_len`=2, bytes 8C 02 00 0E 00 00 00 00, checksum 80 → 8 writes at addresses 0..7 with those bytes; `cpu_run`=1 the cycle after the checksum handshake; `err`=0.
- Same image with checksum 81 → all 8 writes still occur; `err`=1, `cpu_run`=0, `byte_ready`=0 afterwards.
- `start` with `load_len`=0, then `start` with `load_len`=33 (ADDR_W=7) → ERROR one cycle after each; no `mem_we` and no `byte_ready`.
- Test 1 repeated with `byte_valid` high every third cycle → identical writes and result; `mem_we` only in cycles following a handshake.
- `rst_n` low after 3 handshakes → all outputs 0 immediately. A fresh `start` with `load_len`=1 writes from address 0; checksum = XOR of the 4 bytes → RUN.
- While in RUN, `start` with `load_len`=1 → `cpu_run` drops next cycle, `busy`=1, reload proceeds from address 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory boot path.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W    = 7;
  localparam int unsigned IMEM_LEN_W     = 6;
  localparam int unsigned IMEM_BYTES     = 1 << IMEM_ADDR_W;
  localparam int unsigned IMEM_MAX_WORDS = IMEM_BYTES / 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/xor_checksum.sv
// 8-bit XOR accumulator; clear takes priority over enable.
module xor_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a checksummed image into instruction memory, then releases the core.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned LEN_W  = IMEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  localparam int unsigned MAX_WORDS = (1 << ADDR_W) / 4;
  localparam int unsigned TGT_W     = ADDR_W + 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic               mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         mem_wdata_d;
  logic               byte_ready_d, busy_d, cpu_run_d, err_d;
  logic [7:0]         sum_c;
  logic               len_ok_c, start_ok_c, load_c, load_hs_c, check_hs_c, last_c;

  assign len_ok_c   = (load_len != '0) && (32'(load_len) <= MAX_WORDS);
  assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                                (state_q == ST_ERROR));
  assign load_c     = start_ok_c && len_ok_c;
  assign load_hs_c  = (state_q == ST_LOAD)  && byte_valid;
  assign check_hs_c = (state_q == ST_CHECK) && byte_valid;
  assign last_c     = ({1'b0, cnt_q} == tgt_q);

  xor_checksum u_cks (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (load_c),
    .en_i   (load_hs_c),
    .data_i (byte_data),
    .sum_o  (sum_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) state_d = len_ok_c ? ST_LOAD : ST_ERROR;
      end
      ST_LOAD: begin
        if (load_hs_c && last_c) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (check_hs_c) state_d = (byte_data == sum_c) ? ST_RUN : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered copies of the upcoming state's decode.
  always_comb begin
    byte_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    cpu_run_d    = (state_d == ST_RUN);
    err_d        = (state_d == ST_ERROR);
  end

  always_comb begin
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    mem_we_d    = load_hs_c;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if (load_c) begin
      cnt_d = '0;
      tgt_d = TGT_W'({load_len, 2'b00}) - TGT_W'(1);
    end else if (load_hs_c) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
    if (load_hs_c) begin
      mem_addr_d  = cnt_q;
      mem_wdata_d = byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tgt_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      byte_ready <= byte_ready_d;
      busy       <= busy_d;
      cpu_run    <= cpu_run_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: stimulus queues expected writes, a negedge monitor checks them.
module tb_imem_boot_loader;

  localparam int unsigned AW = 7;
  localparam int unsigned LW = 6;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] load_len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, mem_we, cpu_run, busy, err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          wr_seen = 0;
  int unsigned exp_addr = 0;

  logic [7:0] img_a[8] = '{8'h8C, 8'h02, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] img_b[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] img_c[8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_t e;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.a));
        chk("write_data", 32'(mem_wdata), 32'(e.d));
      end
      wr_seen++;
    end
  end

  task automatic chk_status(input string name, input logic run, input logic er,
                            input logic bz, input logic rdy);
    chk({name, "_cpu_run"}, 32'(cpu_run), 32'(run));
    chk({name, "_err"}, 32'(err), 32'(er));
    chk({name, "_busy"}, 32'(busy), 32'(bz));
    chk({name, "_byte_ready"}, 32'(byte_ready), 32'(rdy));
  endtask

  task automatic chk_all_zero(input string name);
    chk_status(name, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    #1 rst_n = 1'b0;
    byte_valid = 1'b0;
    start = 1'b0;
    #1 chk_all_zero(name);
    chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1;
    load_len = LW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit img);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    if (img) begin
      exp_q.push_back('{a: AW'(exp_addr), d: b});
      exp_addr++;
    end
    @(posedge clk);
  endtask

  task automatic run_image(input logic [7:0] img[8], input int n,
                           input logic [7:0] cks, input int gap);
    exp_addr = 0;
    for (int i = 0; i < n; i++) send_byte(img[i], gap, 1'b1);
    send_byte(cks, gap, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    int w0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    #1 rst_n = 1'b1;

    // Nominal two-word load.
    w0 = wr_seen;
    do_start(2);
    chk_status("t1_load", 1'b0, 1'b0, 1'b1, 1'b1);
    run_image(img_a, 8, 8'h80, 0);
    chk_status("t1_done", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_writes", 32'(wr_seen - w0), 32'd8);

    // Bad checksum, entered straight from RUN.
    w0 = wr_seen;
    do_start(2);
    chk_status("t2_load", 1'b0, 1'b0, 1'b1, 1'b1);
    run_image(img_a, 8, 8'h81, 0);
    chk_status("t2_done", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_writes", 32'(wr_seen - w0), 32'd8);

    // Illegal lengths.
    apply_reset("t3_rst");
    w0 = wr_seen;
    do_start(0);
    chk_status("t3_len0", 1'b0, 1'b1, 1'b0, 1'b0);
    apply_reset("t3_rst2");
    do_start(33);
    chk_status("t3_len33", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_status("t3_hold", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_writes", 32'(wr_seen - w0), 32'd0);
    do_start(32);
    chk_status("t3_len32", 1'b0, 1'b0, 1'b1, 1'b1);

    // Sparse byte_valid: one beat in three.
    apply_reset("t4_rst");
    w0 = wr_seen;
    do_start(2);
    run_image(img_a, 8, 8'h80, 2);
    chk_status("t4_done", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_writes", 32'(wr_seen - w0), 32'd8);

    // Reset mid-load, then a fresh one-word image.
    apply_reset("t5_pre");
    do_start(1);
    exp_addr = 0;
    for (int i = 0; i < 3; i++) send_byte(img_c[i], 0, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    byte_valid = 1'b0;
    #1 chk_all_zero("t5_async");
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    w0 = wr_seen;
    do_start(1);
    run_image(img_b, 4, 8'h08, 0);
    chk_status("t5_done", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_writes", 32'(wr_seen - w0), 32'd4);

    // Reload from RUN; a start during LOAD is ignored.
    w0 = wr_seen;
    do_start(1);
    chk_status("t6_reload", 1'b0, 1'b0, 1'b1, 1'b1);
    do_start(0);
    chk_status("t6_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
    run_image(img_c, 4, 8'h04, 0);
    chk_status("t6_done", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_writes", 32'(wr_seen - w0), 32'd4);

    repeat (2) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
